shift_left_chaos_pipe: RTL and testbench
========================================

# shift_left_chaos_pipe

Pipelined, key-locked 32-bit left shifter/rotator with valid/ready handshakes. It complements the key-locked right barrel shifter: same logarithmic five-level structure, with levels 2 and 3 built from `mux_chaos` cells. Each level is registered, so the block can sit in the ALU/crypto datapath at full clock rate. It produces the correct shift only while the loaded 24-bit key matches the design key.

## Interface
Parameters:
- `W`, 32: data width; fixed, only 32 is supported.
- `KEY_W`, 24: key width, taken from the package.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `key_we`  in  1  load `key` into `key_q` at this edge.
- `key`  in  24  lock key.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts a beat this cycle.
- `a`  in  32  operand.
- `shamt`  in  5  shift amount, 0..31.
- `c`  in  1  0 = logical left shift (zero fill); 1 = rotate left.
- `out_valid`  out  1  `y` holds a result.
- `out_ready`  in  1  downstream accepts `y`.
- `y`  out  32  result.

## Operation
- Level i (0..4) shifts the word left by 2^i when the beat's `shamt[i]`=1 and passes it unchanged otherwise.
- Vacated low bits at each level:
  - c=0: filled with 0.
  - c=1: filled with the bits shifted out of the top (rotate).
- The fill source for every vacated bit is a fill mux selecting 0 (c=0) or the wrapped bit (c=1).
- Levels 0, 1 and 4 use plain `mux` cells.
- Levels 2 and 3 use `mux_chaos` cells for both the data muxes and the fill muxes.
  - Key slice index for level i, bit j: s = (j/16) + 2*(i-2), giving 0..3.
  - The cell uses `key_q[6*s+5 : 6*s]`.
- With `key_q == CHAOS_SHL_KEY`, y equals `c ? rotl(a,shamt) : a << shamt` exactly.
- With any other key, y is deterministic and X-free but is not required to be correct.
- `shamt` and `c` are registered alongside the data at every level, so each beat uses its own controls.
- `key_q` is shared by all beats and is not carried per beat.
- `key_we` may be asserted while beats are in flight. The new key affects levels 2 and 3 from the next cycle onward.

## Timing
- Reset values:
  - all stage valid bits 0, so `out_valid`=0;
  - `y`=0 and all stage data 0;
  - `key_q`=0, which is a locked state: software must load the key after reset.
- Pipeline:
  - Five registered levels, s0..s4. s4 drives `y`/`out_valid`.
  - Latency is 5 cycles: a beat accepted at edge k is presented at edge k+4, and `out_valid` is high in the following cycle.
- Stall:
  - `stall = out_valid & ~out_ready`.
  - `in_ready = ~stall`. It is combinational and does not depend on `in_valid`.
  - While stall=1, all stages hold their state and no beat is accepted or lost.
- Bubbles:
  - Without a stall, a stage with valid=0 advances as a bubble. The pipeline does not compress bubbles.
  - Throughput is one beat per cycle when `out_ready` is held at 1.
- Handshake: a beat transfers out on any edge with `out_valid & out_ready`. `y` is stable while `out_valid=1` and `out_ready=0`.
- Simultaneous `key_we` and stall: the key still loads.
- `rst` takes priority over everything:
  - A reset during operation discards all in-flight beats.
  - `out_valid`=0 in the cycle after the reset edge.
- `shamt`=0 passes `a` unchanged for either value of c.

## Structure
- Package `chaos_pkg` holds:
  - `KEY_W`=24, `KEY_SLICE_W`=6, `N_LEVELS`=5;
  - the `CHAOS_SHL_KEY` constant;
  - a packed struct `shl_beat_t` {data[31:0], shamt[4:0], c, valid}.
- Sub-module `shl_chaos_level`:
  - Parameters: `LEVEL` and `LOCKED`.
  - Contents: one level's mux row, fill muxes and stage register with hold-on-stall.
  - Instantiated five times; `LOCKED`=1 for levels 2 and 3.
- The top level contains only `key_q`, the stall logic and the level chain.

## Test plan
- Load `CHAOS_SHL_KEY`; a=0x0000_0001, shamt=31, c=0 → y=0x8000_0000 five cycles after acceptance.
- Correct key; a=0x8000_0001, shamt=4, c=1 → y=0x0000_0018. Then shamt=0, a=0xDEAD_BEEF → y=0xDEAD_BEEF.
- Correct key; 8 back-to-back beats with random a, shamt, c; `out_ready`=0 for 4 cycles mid-stream → `in_ready`=0 during the stall; all 8 results match the model, in order, with no duplicates.
- Reset asserted with 3 beats in flight → `out_valid`=0 the next cycle, `key_q`=0, no stale beat emerges later.
- `key_q`=~`CHAOS_SHL_KEY`; sweep a=0xFFFF_FFFF, shamt 0..31 → `y` is never X. Reload the correct key mid-stream → beats entering level 2 after the load match the model.
- Full random regression (10k beats, random stalls, correct key) against the reference model → zero mismatches.

Source files
------------

// File: rtl/shift_left_chaos_pipe_pkg.sv
// chaos_pkg: shared constants, the per-beat pipeline record and the two mux
// cells used by the key-locked left shifter.
//   KEY_W / KEY_SLICE_W / N_LEVELS : key width, per-cell key slice width, level count
//   CHAOS_SHL_KEY                  : the only key value that yields correct shifts
//   shl_beat_t                     : data word plus its own shamt/c controls and valid
//   mux_cell / mux_chaos_cell      : plain 2:1 mux and the key-locked 2:1 mux
package chaos_pkg;

    localparam int KEY_W       = 24;
    localparam int KEY_SLICE_W = 6;
    localparam int N_LEVELS    = 5;

    localparam logic [KEY_W-1:0] CHAOS_SHL_KEY = 24'h5A3CE1;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic        c;
        logic        valid;
    } shl_beat_t;

    function automatic logic mux_cell(input logic sel, input logic d0, input logic d1);
        return sel ? d1 : d0;
    endfunction

    // A wrong key slice inverts the effective select, so a locked cell picks
    // the opposite input; the output is always one of the two real inputs,
    // which keeps the locked datapath deterministic and X-free.
    function automatic logic mux_chaos_cell(input logic                   sel,
                                            input logic                   d0,
                                            input logic                   d1,
                                            input logic [KEY_SLICE_W-1:0] kslice,
                                            input logic [KEY_SLICE_W-1:0] kref);
        logic eff_sel;
        eff_sel = sel ^ (kslice != kref);
        return eff_sel ? d1 : d0;
    endfunction

endpackage

// File: rtl/shift_left_chaos_pipe_if.sv
// shift_left_chaos_pipe_if: key load port, input beat handshake and output
// handshake of the key-locked left shifter.
//   master : the side that drives operands and out_ready (bench / upstream)
//   slave  : the shifter itself
interface shift_left_chaos_pipe_if;
    import chaos_pkg::*;

    logic             key_we;
    logic [KEY_W-1:0] key;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      a;
    logic [4:0]       shamt;
    logic             c;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      y;

    modport master (
        output key_we, key, in_valid, a, shamt, c, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  key_we, key, in_valid, a, shamt, c, out_ready,
        output in_ready, out_valid, y
    );

endinterface

// File: rtl/shift_left_chaos_pipe_level.sv
// shl_chaos_level: one registered level of the left shifter. Shifts the beat
// left by 2**LEVEL when the beat's shamt[LEVEL] is set, filling vacated low
// bits with zero (c=0) or the bits wrapped from the top (c=1).
//   LEVEL  : level index 0..4
//   LOCKED : 1 = data and fill muxes are key-locked mux_chaos cells
//   clk, rst : clock, synchronous active-high reset
//   stall    : hold the stage register
//   key_q    : shared lock key
//   beat_in / beat_out : beat entering the level / registered beat leaving it
module shl_chaos_level
    import chaos_pkg::*;
#(
    parameter int LEVEL  = 0,
    parameter bit LOCKED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [KEY_W-1:0] key_q,
    input  shl_beat_t        beat_in,
    output shl_beat_t        beat_out
);

    localparam int SH = 1 << LEVEL;

    logic [31:0] shifted;
    logic [31:0] next_data;
    logic        unused_key;

    // Each level only reads its own key slices; the rest is intentionally ignored.
    assign unused_key = ^key_q;

    for (genvar j = 0; j < 32; j++) begin : g_bit
        if (LOCKED) begin : g_locked
            // Key slice s = j/16 + 2*(LEVEL-2): level 2 uses slices 0/1, level 3 uses 2/3.
            localparam int S = j / 16 + 2 * (LEVEL - 2);
            localparam logic [KEY_SLICE_W-1:0] KREF = CHAOS_SHL_KEY[KEY_SLICE_W*S +: KEY_SLICE_W];
            if (j >= SH) begin : g_move
                assign shifted[j] = beat_in.data[j-SH];
            end else begin : g_fill
                assign shifted[j] = mux_chaos_cell(beat_in.c, 1'b0, beat_in.data[32-SH+j],
                                                   key_q[KEY_SLICE_W*S +: KEY_SLICE_W], KREF);
            end
            assign next_data[j] = mux_chaos_cell(beat_in.shamt[LEVEL], beat_in.data[j], shifted[j],
                                                 key_q[KEY_SLICE_W*S +: KEY_SLICE_W], KREF);
        end else begin : g_plain
            if (j >= SH) begin : g_move
                assign shifted[j] = beat_in.data[j-SH];
            end else begin : g_fill
                assign shifted[j] = mux_cell(beat_in.c, 1'b0, beat_in.data[32-SH+j]);
            end
            assign next_data[j] = mux_cell(beat_in.shamt[LEVEL], beat_in.data[j], shifted[j]);
        end
    end

    // Stage register: the controls travel with the data so every beat keeps its own shamt/c.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_out <= '0;
        end else if (!stall) begin
            beat_out.data  <= next_data;
            beat_out.shamt <= beat_in.shamt;
            beat_out.c     <= beat_in.c;
            beat_out.valid <= beat_in.valid;
        end
    end

endmodule

// File: rtl/shift_left_chaos_pipe.sv
// shift_left_chaos_pipe: five-stage pipelined key-locked 32-bit left
// shifter/rotator. y = c ? rotl(a,shamt) : a << shamt while key_q holds
// CHAOS_SHL_KEY; latency 5 cycles, one beat per cycle without back-pressure.
//   W   : data width (only 32)
//   clk : clock
//   rst : synchronous active-high reset
//   sif : key load, input and output handshakes (slave side)
module shift_left_chaos_pipe
    import chaos_pkg::*;
#(
    parameter int W = 32
) (
    input logic                    clk,
    input logic                    rst,
    shift_left_chaos_pipe_if.slave sif
);

    logic [KEY_W-1:0] key_q;
    logic             stall;
    logic             unused_ctrl;
    shl_beat_t        stage [0:N_LEVELS];

    // Key register is shared by all beats; a load during a stall still lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '0;
        end else if (sif.key_we) begin
            key_q <= sif.key;
        end
    end

    // A presented but unaccepted result freezes the whole chain.
    assign stall        = stage[N_LEVELS].valid & ~sif.out_ready;
    assign sif.in_ready = ~stall;

    assign stage[0] = '{data: sif.a, shamt: sif.shamt, c: sif.c, valid: sif.in_valid};

    for (genvar i = 0; i < N_LEVELS; i++) begin : g_level
        shl_chaos_level #(
            .LEVEL  (i),
            .LOCKED ((i == 2) || (i == 3))
        ) u_level (
            .clk      (clk),
            .rst      (rst),
            .stall    (stall),
            .key_q    (key_q),
            .beat_in  (stage[i]),
            .beat_out (stage[i+1])
        );
    end

    assign sif.out_valid = stage[N_LEVELS].valid;
    assign sif.y         = stage[N_LEVELS].data[W-1:0];

    // The final stage's controls have no further consumer.
    assign unused_ctrl = ^{stage[N_LEVELS].shamt, stage[N_LEVELS].c};

endmodule

// File: tb/tb_shift_left_chaos_pipe.sv
// tb_shift_left_chaos_pipe: scoreboard bench for shift_left_chaos_pipe.
// Expected results are queued when a beat is accepted and compared in order
// when the DUT hands a result out.
module tb_shift_left_chaos_pipe;
    import chaos_pkg::*;

    typedef struct {
        logic [31:0] exp;
        bit          check;
        int          acc_cycle;
        bit          lat;
    } sb_entry_t;

    logic clk;
    logic rst;
    shift_left_chaos_pipe_if sif();

    shift_left_chaos_pipe #(.W(32)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    int               total;
    int               bad;
    int               cycle;
    bit               accepted;
    bit               lat_mode;
    logic [KEY_W-1:0] model_key;
    sb_entry_t        sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls forever.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [4:0] sh, input logic c);
        logic [63:0] dbl;
        dbl = {a, a} << sh;
        return c ? dbl[63:32] : (a << sh);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h (cycle %0d)", tag, got, want, cycle);
        end
    endtask

    // Drive one cycle at the falling edge, observe the handshakes #1 later,
    // then let the rising edge happen.
    task automatic applyStimulus(input logic        in_valid,
                                 input logic [31:0] a,
                                 input logic [4:0]  shamt,
                                 input logic        c,
                                 input logic [31:0] exp,
                                 input logic        out_ready,
                                 input logic        key_we,
                                 input logic [23:0] key);
        logic [KEY_W-1:0] key_next;
        sb_entry_t        e;
        sif.in_valid  = in_valid;
        sif.a         = a;
        sif.shamt     = shamt;
        sif.c         = c;
        sif.out_ready = out_ready;
        sif.key_we    = key_we;
        sif.key       = key;
        #1;
        checkOutput("in_ready", {31'b0, sif.in_ready}, {31'b0, !(sif.out_valid && !out_ready)});
        key_next = key_we ? key : model_key;
        accepted = in_valid && sif.in_ready;
        if (accepted) sb.push_back('{exp, key_next == CHAOS_SHL_KEY, cycle, lat_mode});
        if (sif.out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                if (e.check) checkOutput("y", sif.y, e.exp);
                else checkOutput("y_noX", {31'b0, $isunknown(sif.y)}, 32'd0);
                if (e.lat) checkOutput("latency", cycle - e.acc_cycle, 32'd5);
            end
        end
        model_key = key_next;
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, '0, 1, 0, '0);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (sb.size() > 0 && n < max_cycles) begin
            applyStimulus(0, '0, '0, 0, '0, 1, 0, '0);
            n++;
        end
        checkOutput("drain_left", sb.size(), 32'd0);
        idle(4);
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [4:0] sh, input logic c, input logic [31:0] exp);
        applyStimulus(1, a, sh, c, exp, 1, 0, '0);
        if (!accepted) checkOutput("accept", 32'd0, 32'd1);
    endtask

    logic [31:0] ra [8];
    logic [4:0]  rs [8];
    logic        rc [8];

    initial begin
        int idx;
        int budget;
        int start;
        int rel;
        int beats;
        logic [31:0] va;
        logic [4:0]  vs;
        logic        vc;

        total = 0; bad = 0; cycle = 0; lat_mode = 0; model_key = '0;
        rst = 1'b1;
        sif.in_valid = 0; sif.a = '0; sif.shamt = '0; sif.c = 0;
        sif.out_ready = 0; sif.key_we = 0; sif.key = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_out_valid", {31'b0, sif.out_valid}, 32'd0);
        checkOutput("rst_y", sif.y, 32'd0);
        checkOutput("rst_key_q", {8'b0, dut.key_q}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, sif.in_ready}, 32'd1);
        @(negedge clk);

        // Unlock and run the directed cases with latency checking.
        applyStimulus(0, '0, '0, 0, '0, 1, 1, CHAOS_SHL_KEY);
        lat_mode = 1;
        send_beat(32'h0000_0001, 5'd31, 0, 32'h8000_0000);
        drain(20);
        send_beat(32'h8000_0001, 5'd4, 1, 32'h0000_0018);
        send_beat(32'hDEAD_BEEF, 5'd0, 0, 32'hDEAD_BEEF);
        send_beat(32'hDEAD_BEEF, 5'd0, 1, 32'hDEAD_BEEF);
        send_beat(32'hF000_000F, 5'd16, 0, 32'h000F_0000);
        send_beat(32'hF000_000F, 5'd16, 1, 32'h000F_F000);
        drain(20);
        lat_mode = 0;

        // Eight back-to-back beats with a four-cycle output stall mid-stream.
        for (int i = 0; i < 8; i++) begin
            ra[i] = $urandom; rs[i] = 5'($urandom_range(0, 31)); rc[i] = 1'($urandom_range(0, 1));
        end
        idx = 0; budget = 0; start = cycle;
        while (idx < 8 && budget < 40) begin
            rel = cycle - start;
            applyStimulus(1, ra[idx], rs[idx], rc[idx], ref_model(ra[idx], rs[idx], rc[idx]),
                          !(rel >= 6 && rel <= 9), 0, '0);
            if (accepted) idx++;
            budget++;
        end
        checkOutput("b2b_accepted", idx, 32'd8);
        drain(30);

        // Reset with three beats in flight, one of them already presented and stalled.
        for (int i = 0; i < 3; i++) send_beat(32'h1234_5678 + i, 5'(i + 1), 1'(i), '0);
        for (int i = 0; i < 3; i++) applyStimulus(0, '0, '0, 0, '0, 0, 0, '0);
        checkOutput("pre_rst_out_valid", {31'b0, sif.out_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        cycle++;
        #1;
        rst = 1'b0;
        checkOutput("post_rst_out_valid", {31'b0, sif.out_valid}, 32'd0);
        checkOutput("post_rst_key_q", {8'b0, dut.key_q}, 32'd0);
        sb.delete();
        model_key = '0;
        @(negedge clk);
        idle(10);

        // Wrong key sweep, reloading the correct key halfway through.
        applyStimulus(0, '0, '0, 0, '0, 1, 1, ~CHAOS_SHL_KEY);
        for (int s = 0; s < 32; s++) begin
            applyStimulus(1, 32'hFFFF_FFFF, 5'(s), 1'(s & 1), ref_model(32'hFFFF_FFFF, 5'(s), 1'(s & 1)),
                          1, s == 16, CHAOS_SHL_KEY);
            if (!accepted) checkOutput("sweep_accept", 32'd0, 32'd1);
        end
        drain(20);

        // Random regression with random input gaps and output stalls.
        beats = 0; budget = 0;
        while (beats < 10000 && budget < 40000) begin
            va = $urandom; vs = 5'($urandom_range(0, 31)); vc = 1'($urandom_range(0, 1));
            applyStimulus($urandom_range(0, 9) < 8, va, vs, vc, ref_model(va, vs, vc),
                          $urandom_range(0, 3) != 0, 0, '0);
            if (accepted) beats++;
            budget++;
        end
        checkOutput("regress_beats", beats, 32'd10000);
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
